lsu_dmem_if: RTL and testbench
==============================

Name: lsu_dmem_if

Overview:
Load/store initiator that drives the byte-enabled data-memory port (daddr/dwdata/we/drdata) on behalf of the core's execute stage. It accepts one load or store request per handshake and computes the byte lanes and write enables. It shifts store data, and splits misaligned accesses into two word accesses. Load data is realigned and sign/zero-extended, then returned with a single-cycle response strobe. It sits between the execute/memory stage and the dmem block, which is combinational-read and posedge-write.

Parameters:
XLEN, 32, data/address width; must equal the codebase MSB-LSB+1
BYTES, 4, bytes per memory word; fixed at XLEN/8

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (IDLE only)
req_store  input  1  1=store, 0=load
req_funct3  input  3  RV32I funct3: loads 0=LB,1=LH,2=LW,4=LBU,5=LHU; stores 0=SB,1=SH,2=SW
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  store data, right-aligned
rsp_valid  output  1  one-cycle completion strobe
rsp_err  output  1  qualified by rsp_valid; illegal funct3 (or misaligned, see macro)
rsp_rdata  output  XLEN  load result; 0 for stores and errors
daddr  output  XLEN  word-aligned memory address
dwdata  output  XLEN  lane-positioned store data
we  output  4  per-byte write enables
drdata  input  XLEN  combinational read data for daddr

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous, active-high. On rst, state goes to IDLE. Reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, daddr=0, dwdata=0, we=0.
- we is gated combinationally with !rst, so no memory write can occur in a reset cycle, including reset asserted during ACC0 or ACC1.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: req_ready=1. When req_valid is high, latch addr, wdata, funct3 and store, then go to ACC0. If funct3 is illegal, go straight to RESP with the error flag set and perform no access.
- Byte lanes: off=addr[1:0]; size mask = 0x1/0x3/0xF for byte/half/word; mask8 = size_mask << off (8 bits). Store data: wdata64 = {32'b0, wdata} << (8*off).
- ACC0: daddr=addr&~3, we = store ? mask8[3:0] : 0, dwdata = wdata64[31:0]. Capture drdata into lo_buf. If mask8[7:4] != 0, go to ACC1; otherwise go to RESP.
- ACC1: daddr = (addr&~3)+4, modulo 2^32, so 0xFFFFFFFC wraps to 0x0. we = store ? mask8[7:4] : 0, dwdata = wdata64[63:32]. Capture drdata into hi_buf, then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. req_ready=0 in this cycle, so back-to-back requests see one bubble.
- Load result: raw = {hi_buf, lo_buf} >> (8*off). Take the low 8, 16 or 32 bits. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. rsp_rdata is registered and held until the next RESP.
- Latency, measured from the accept edge: aligned or single-word access gives rsp_valid 2 cycles later. Word-crossing access gives 3 cycles. Illegal funct3 gives 1 cycle.
- Outside ACC0/ACC1: we=0. daddr and dwdata hold their last value.
- Request inputs are ignored outside IDLE.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: any access with mask8[7:4] != 0 (crosses a word) is not performed. The FSM goes IDLE->RESP with rsp_err=1, rsp_rdata=0 and we=0 throughout. Latency is 1 cycle.
- Undefined: word-crossing accesses are split via ACC1 as described above. rsp_err is raised only for illegal funct3.

Test Plan:
Preload memory: word 0x10=0x8899AABB, word 0x14=0x11223344.
- LW 0x10 -> daddr=0x10, we=0; rsp_valid 2 cycles after accept; rsp_rdata=0x8899AABB, rsp_err=0.
- LB 0x13 -> rsp_rdata=0xFFFFFF88. LBU 0x13 -> 0x00000088. LH 0x12 -> 0xFFFF8899.
- SH 0x12, wdata=0x0000BEEF -> one ACC cycle with daddr=0x10, we=4'b1100, dwdata=0xBEEF0000. A following LW 0x10 returns 0xBEEFAABB.
- LW 0x13 (macro undefined) -> ACC0 daddr=0x10, ACC1 daddr=0x14; rsp_valid 3 cycles after accept; rsp_rdata=0x22334488. With MISALIGN_TRAP_EN: rsp_err=1, rsp_rdata=0, no non-zero we, latency 1.
- SW 0x16, wdata=0xDEADBEEF -> ACC0: daddr=0x14, we=4'b1100, dwdata=0xBEEF0000. ACC1: daddr=0x18, we=4'b0011, dwdata=0x0000DEAD.
- Load with funct3=3 -> rsp_err=1 one cycle after accept, no access. Separately, assert rst in the ACC0 cycle of SW 0x10 -> we=0 that cycle, memory word unchanged, req_ready=1 the next cycle, and no rsp_valid.

Source files
------------

// File: rtl/lsu_dmem_if_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_dmem_if_if : core request/response and data-memory bus for lsu_dmem_if |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface lsu_dmem_if_if #(
    parameter int XLEN  = 32,
    parameter int BYTES = XLEN / 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic [2:0]       req_funct3;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic             rsp_valid;
    logic             rsp_err;
    logic [XLEN-1:0]  rsp_rdata;
    logic [XLEN-1:0]  daddr;
    logic [XLEN-1:0]  dwdata;
    logic [BYTES-1:0] we;
    logic [XLEN-1:0]  drdata;

    // master: the core plus the data memory that surround the LSU
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, drdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, daddr, dwdata, we
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, drdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, daddr, dwdata, we
    );
endinterface
`default_nettype wire

// File: rtl/lsu_dmem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_dmem_if : load/store initiator for a byte-enabled data memory port.    |
// | Optional macro MISALIGN_TRAP_EN: word-crossing accesses error, no split.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lsu_dmem_if #(
    parameter int XLEN  = 32,
    parameter int BYTES = XLEN / 8
) (
    input  wire logic    clk,
    input  wire logic    rst,
    lsu_dmem_if_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    function automatic logic [7:0] f_mask8(input logic [1:0] sz, input logic [1:0] off);
        logic [7:0] size;
        case (sz)
            2'd0:    size = 8'h01;
            2'd1:    size = 8'h03;
            default: size = 8'h0F;
        endcase
        f_mask8 = size << off;
    endfunction

    function automatic logic f_illegal(input logic st, input logic [2:0] f3);
        if (st)
            f_illegal = (f3 > 3'd2);
        else
            f_illegal = (f3 == 3'd3) || (f3 > 3'd5);
    endfunction

    // funct3[2] selects zero-extension (LBU/LHU)
    function automatic logic [XLEN-1:0] f_extend(input logic [2:0] f3, input logic [XLEN-1:0] raw);
        case (f3[1:0])
            2'd0:    f_extend = {{(XLEN-8){~f3[2] & raw[7]}}, raw[7:0]};
            2'd1:    f_extend = {{(XLEN-16){~f3[2] & raw[15]}}, raw[15:0]};
            default: f_extend = raw;
        endcase
    endfunction

    state_t           r_state;
    logic             r_ready;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic             r_store;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;
    logic [7:0]       r_mask8;
    logic [XLEN-1:0]  r_wdata_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_rdata;
    logic [XLEN-1:0]  r_daddr;
    logic [XLEN-1:0]  r_dwdata;
    logic [BYTES-1:0] r_we;

    logic [1:0]        w_req_off;
    logic [7:0]        w_req_mask8;
    logic [2*XLEN-1:0] w_req_wdata64;
    logic [XLEN-1:0]   w_req_word;
    logic              w_req_illegal;
    logic              w_req_trap;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_raw;
    logic [XLEN-1:0]   w_load;

    assign w_req_off     = bus.req_addr[1:0];
    assign w_req_mask8   = f_mask8(bus.req_funct3[1:0], w_req_off);
    assign w_req_wdata64 = {{XLEN{1'b0}}, bus.req_wdata} << {w_req_off, 3'b000};
    assign w_req_word    = {bus.req_addr[XLEN-1:2], 2'b00};
    assign w_req_illegal = f_illegal(bus.req_store, bus.req_funct3);

`ifdef MISALIGN_TRAP_EN
    assign w_req_trap = |w_req_mask8[7:4];
`else
    assign w_req_trap = 1'b0;
`endif

    // Read data is combinational, so the word being fetched this cycle is used directly
    assign w_lo   = (r_state == S_ACC0) ? bus.drdata : r_lo;
    assign w_hi   = (r_state == S_ACC1) ? bus.drdata : '0;
    assign w_raw  = XLEN'({w_hi, w_lo} >> {r_off, 3'b000});
    assign w_load = f_extend(r_f3, w_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
            r_daddr     <= '0;
            r_dwdata    <= '0;
            r_we        <= '0;
            r_store     <= 1'b0;
            r_f3        <= '0;
            r_off       <= '0;
            r_mask8     <= '0;
            r_wdata_hi  <= '0;
            r_lo        <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_ready    <= 1'b0;
                        r_store    <= bus.req_store;
                        r_f3       <= bus.req_funct3;
                        r_off      <= w_req_off;
                        r_mask8    <= w_req_mask8;
                        r_wdata_hi <= w_req_wdata64[2*XLEN-1:XLEN];
                        if (w_req_illegal || w_req_trap) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rdata     <= '0;
                        end else begin
                            r_state  <= S_ACC0;
                            r_daddr  <= w_req_word;
                            r_dwdata <= w_req_wdata64[XLEN-1:0];
                            r_we     <= bus.req_store ? w_req_mask8[3:0] : '0;
                        end
                    end
                end
                S_ACC0: begin
                    r_lo <= bus.drdata;
                    if (|r_mask8[7:4]) begin
                        r_state  <= S_ACC1;
                        r_daddr  <= r_daddr + XLEN'(4);
                        r_dwdata <= r_wdata_hi;
                        r_we     <= r_store ? r_mask8[7:4] : '0;
                    end else begin
                        r_state     <= S_RESP;
                        r_we        <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rdata     <= r_store ? '0 : w_load;
                    end
                end
                S_ACC1: begin
                    r_state     <= S_RESP;
                    r_we        <= '0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rdata     <= r_store ? '0 : w_load;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rdata;
    assign bus.daddr     = r_daddr;
    assign bus.dwdata    = r_dwdata;
    assign bus.we        = rst ? '0 : r_we;
endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lsu_dmem_if : scoreboard bench for lsu_dmem_if with a byte-lane memory  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_lsu_dmem_if;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;

    lsu_dmem_if_if #(.XLEN(32)) bus ();

    lsu_dmem_if #(.XLEN(32), .BYTES(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    assign bus.drdata = mem[bus.daddr[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h000000A5;
            mem[4] <= 32'h8899AABB;
            mem[5] <= 32'h11223344;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.we[b]) mem[bus.daddr[7:2]][8*b +: 8] <= bus.dwdata[8*b +: 8];
        end
    end

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb_q [$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] ob_daddr  [1:6];
    logic [3:0]  ob_we     [1:6];
    logic [31:0] ob_dwdata [1:6];

`ifdef MISALIGN_TRAP_EN
    localparam bit c_trap = 1'b1;
`else
    localparam bit c_trap = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge; ob_* hold the bus seen in cycles 1..latency
    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                           input logic exp_err, input logic [31:0] exp_rd);
        int   w;
        int   lat;
        exp_t e;
        sb_q.push_back('{err: exp_err, rd: exp_rd});
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) check({tag, " ready timeout"}, 32'd0, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            ob_daddr[k]  = bus.daddr;
            ob_we[k]     = bus.we;
            ob_dwdata[k] = bus.dwdata;
            if (bus.rsp_valid) lat = k;
        end
        check({tag, " latency"}, lat, exp_lat);
        e = sb_q.pop_front();
        if (lat != 0) begin
            check({tag, " rsp_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
            check({tag, " rsp_rdata"}, bus.rsp_rdata, e.rd);
        end
        @(negedge clk);
        check({tag, " rsp_valid one cycle"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset daddr",     bus.daddr,     32'h0);
        check("reset dwdata",    bus.dwdata,    32'h0);
        check("reset we",        {28'd0, bus.we}, 32'd0);
        mem_init = 1'b0;
        rst      = 1'b0;
        @(negedge clk);

        run_req("LW 0x10", 1'b0, 3'd2, 32'h10, 32'h0, 2, 1'b0, 32'h8899AABB);
        check("LW 0x10 daddr", ob_daddr[1], 32'h10);
        check("LW 0x10 we", {28'd0, ob_we[1]}, 32'd0);
        run_req("LB 0x13",  1'b0, 3'd0, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFF88);
        run_req("LBU 0x13", 1'b0, 3'd4, 32'h13, 32'h0, 2, 1'b0, 32'h00000088);
        run_req("LH 0x12",  1'b0, 3'd1, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF8899);

        run_req("LW 0x13", 1'b0, 3'd2, 32'h13, 32'h0, c_trap ? 1 : 3, c_trap,
                c_trap ? 32'h0 : 32'h22334488);
`ifdef MISALIGN_TRAP_EN
        check("LW 0x13 no write", {28'd0, ob_we[1]}, 32'd0);
`else
        check("LW 0x13 ACC0 daddr", ob_daddr[1], 32'h10);
        check("LW 0x13 ACC1 daddr", ob_daddr[2], 32'h14);
`endif

        run_req("SH 0x12", 1'b1, 3'd1, 32'h12, 32'h0000BEEF, 2, 1'b0, 32'h0);
        check("SH 0x12 daddr",  ob_daddr[1], 32'h10);
        check("SH 0x12 we",     {28'd0, ob_we[1]}, 32'hC);
        check("SH 0x12 dwdata", ob_dwdata[1], 32'hBEEF0000);
        run_req("LW 0x10 after SH", 1'b0, 3'd2, 32'h10, 32'h0, 2, 1'b0, 32'hBEEFAABB);

        run_req("SW 0x16", 1'b1, 3'd2, 32'h16, 32'hDEADBEEF, c_trap ? 1 : 3, c_trap, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("SW 0x16 no write", {28'd0, ob_we[1]}, 32'd0);
`else
        check("SW 0x16 ACC0 daddr",  ob_daddr[1], 32'h14);
        check("SW 0x16 ACC0 we",     {28'd0, ob_we[1]}, 32'hC);
        check("SW 0x16 ACC0 dwdata", ob_dwdata[1], 32'hBEEF0000);
        check("SW 0x16 ACC1 daddr",  ob_daddr[2], 32'h18);
        check("SW 0x16 ACC1 we",     {28'd0, ob_we[2]}, 32'h3);
        check("SW 0x16 ACC1 dwdata", ob_dwdata[2], 32'h0000DEAD);
`endif
        run_req("LW 0x14", 1'b0, 3'd2, 32'h14, 32'h0, 2, 1'b0, c_trap ? 32'h11223344 : 32'hBEEF3344);
        run_req("LW 0x18", 1'b0, 3'd2, 32'h18, 32'h0, 2, 1'b0, c_trap ? 32'h0 : 32'h0000DEAD);

        run_req("LHU 0x11", 1'b0, 3'd5, 32'h11, 32'h0, 2, 1'b0, 32'h0000EFAA);
        run_req("LH 0x13",  1'b0, 3'd1, 32'h13, 32'h0, c_trap ? 1 : 3, c_trap,
                c_trap ? 32'h0 : 32'h000044BE);
        run_req("LH wrap", 1'b0, 3'd1, 32'hFFFFFFFF, 32'h0, c_trap ? 1 : 3, c_trap,
                c_trap ? 32'h0 : 32'hFFFFA500);
`ifndef MISALIGN_TRAP_EN
        check("LH wrap ACC0 daddr", ob_daddr[1], 32'hFFFFFFFC);
        check("LH wrap ACC1 daddr", ob_daddr[2], 32'h0);
`endif

        run_req("load f3=3", 1'b0, 3'd3, 32'h10, 32'h0, 1, 1'b1, 32'h0);
        check("load f3=3 no write", {28'd0, ob_we[1]}, 32'd0);
        run_req("load f3=6",  1'b0, 3'd6, 32'h10, 32'h0, 1, 1'b1, 32'h0);
        run_req("store f3=4", 1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
        check("store f3=4 no write", {28'd0, ob_we[1]}, 32'd0);

        // Reset lands in the ACC0 cycle of SW 0x10; the write must be suppressed
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst SW ACC0 we before rst", {28'd0, bus.we}, 32'hF);
        rst = 1'b1;
        #1 check("rst SW we gated", {28'd0, bus.we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst SW req_ready", {31'd0, bus.req_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("rst SW no rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            @(negedge clk);
        end
        check("rst SW mem unchanged", mem[4], 32'hBEEFAABB);
        run_req("LW 0x10 after rst", 1'b0, 3'd2, 32'h10, 32'h0, 2, 1'b0, 32'hBEEFAABB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
